// File: rtl/regfile_read_arbiter.sv
// Two-port round-robin arbiter in front of a shared register read mux.
// One grant per cycle; the selected word comes back with a valid strobe one cycle later.
module regfile_read_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Stall,
  input  logic          ReqA,
  input  logic [AW-1:0] AddrA,
  output logic          GntA,
  output logic [DW-1:0] RdataA,
  output logic          RvalidA,
  input  logic          ReqB,
  input  logic [AW-1:0] AddrB,
  output logic          GntB,
  output logic [DW-1:0] RdataB,
  output logic          RvalidB,
  output logic [AW-1:0] Sel,
  input  logic [DW-1:0] Dout
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e          ptr_q, ptr_d;
  logic [AW-1:0] sel_q, sel_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          rvalid_a_q, rvalid_b_q;
  logic          gnt_a, gnt_b, both;
  logic [DW-1:0] rd_word;

  // Grants are masked by reset so nothing looks accepted while the flops are held.
  assign both  = ReqA && ReqB;
  assign gnt_a = Reset_n && !Stall && ReqA && (!ReqB || ptr_q == PTR_A);
  assign gnt_b = Reset_n && !Stall && ReqB && (!ReqA || ptr_q == PTR_B);

  assign rd_word = (ZERO_R0 && sel_d == '0) ? '0 : Dout;

  always_comb begin
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (gnt_a) begin
      sel_d     = AddrA;
      rdata_a_d = rd_word;
    end else if (gnt_b) begin
      sel_d     = AddrB;
      rdata_b_d = rd_word;
    end
    // Priority only moves on real contention, toward the loser.
    if (both && (gnt_a || gnt_b))
      ptr_d = gnt_a ? PTR_B : PTR_A;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q      <= PTR_A;
      sel_q      <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= gnt_a;
      rvalid_b_q <= gnt_b;
    end
  end

  assign GntA    = gnt_a;
  assign GntB    = gnt_b;
  assign Sel     = sel_d;
  assign RdataA  = rdata_a_q;
  assign RdataB  = rdata_b_q;
  assign RvalidA = rvalid_a_q;
  assign RvalidB = rvalid_b_q;

endmodule
